// File: rtl/cdc_tx_scheduler_if.sv
// Requester/CDC-channel bundle for cdc_tx_scheduler: request side in, held word + enable level out.
// The slave modport is the scheduler's view; master is the requesters/destination view.
interface cdc_tx_scheduler_if #(
    parameter int NUM_REQ   = 2,
    parameter int BUS_WIDTH = 8
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*BUS_WIDTH-1:0] req_data;
    logic                         ack_async;
    logic [NUM_REQ-1:0]           req_grant;
    logic [BUS_WIDTH-1:0]         unsync_bus;
    logic                         bus_enable;
    logic                         done;
    logic                         timeout_err;
    logic                         busy;

    modport master (
        output req_valid, req_data, ack_async,
        input  req_grant, unsync_bus, bus_enable, done, timeout_err, busy
    );

    modport slave (
        input  req_valid, req_data, ack_async,
        output req_grant, unsync_bus, bus_enable, done, timeout_err, busy
    );
endinterface

// File: rtl/cdc_tx_scheduler.sv
// Round-robin owner of one 4-phase CDC data channel; grant+word one edge after IDLE sample, enable one edge later.
// Requesters hold req_valid until granted; a word is released only after ack falls or SEND times out.
module cdc_tx_scheduler #(
    parameter int NUM_REQ        = 2,
    parameter int BUS_WIDTH      = 8,
    parameter int NUM_STAGES     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                CLK,
    input  logic                RST,
    cdc_tx_scheduler_if.slave   s_if
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_SEND    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t                 r_state;
    logic [PTR_W-1:0]       r_ptr;
    logic [CNT_W-1:0]       r_cnt;
    logic [NUM_STAGES-1:0]  r_ack_sync;
    logic [BUS_WIDTH-1:0]   r_bus;
    logic [NUM_REQ-1:0]     r_grant;
    logic                   r_enable;
    logic                   r_done;
    logic                   r_timeout;
    logic                   r_busy;

    state_t                 w_state_nxt;
    logic [PTR_W-1:0]       w_ptr_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [BUS_WIDTH-1:0]   w_bus_nxt;
    logic [NUM_REQ-1:0]     w_grant_nxt;
    logic                   w_enable_nxt;
    logic                   w_done_nxt;
    logic                   w_timeout_nxt;
    logic                   w_ack_s;
    logic                   w_found;
    logic [PTR_W-1:0]       w_win;
    logic [PTR_W-1:0]       w_idx;

    assign w_ack_s = r_ack_sync[NUM_STAGES-1];

    // First valid requester at or cyclically above the pointer wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = PTR_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && s_if.req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_bus_nxt     = r_bus;
        w_grant_nxt   = '0;
        w_enable_nxt  = 1'b0;
        w_done_nxt    = 1'b0;
        w_timeout_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_SETUP;
                    w_bus_nxt   = s_if.req_data[int'(w_win)*BUS_WIDTH +: BUS_WIDTH];
                    w_grant_nxt = NUM_REQ'(1) << w_win;
                    w_ptr_nxt   = (w_win == PTR_LAST) ? '0 : w_win + PTR_W'(1);
                end
            end
            ST_SETUP: begin
                w_state_nxt  = ST_SEND;
                w_cnt_nxt    = '0;
                w_enable_nxt = 1'b1;
            end
            ST_SEND: begin
                w_enable_nxt = 1'b1;
                // An ack arriving in the last allowed cycle still counts as success.
                if (w_ack_s) begin
                    w_state_nxt  = ST_RELEASE;
                    w_enable_nxt = 1'b0;
                    w_done_nxt   = 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt   = ST_RELEASE;
                    w_enable_nxt  = 1'b0;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (!w_ack_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_ack_sync <= '0;
            r_bus      <= '0;
            r_grant    <= '0;
            r_enable   <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ack_sync <= {r_ack_sync[NUM_STAGES-2:0], s_if.ack_async};
            r_bus      <= w_bus_nxt;
            r_grant    <= w_grant_nxt;
            r_enable   <= w_enable_nxt;
            r_done     <= w_done_nxt;
            r_timeout  <= w_timeout_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
        end
    end

    assign s_if.req_grant   = r_grant;
    assign s_if.unsync_bus  = r_bus;
    assign s_if.bus_enable  = r_enable;
    assign s_if.done        = r_done;
    assign s_if.timeout_err = r_timeout;
    assign s_if.busy        = r_busy;
endmodule

// File: tb/tb_cdc_tx_scheduler.sv
// Directed bench for cdc_tx_scheduler: inputs driven and outputs sampled on the falling clock edge.
module tb_cdc_tx_scheduler;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    cdc_tx_scheduler_if #(.NUM_REQ(2), .BUS_WIDTH(8)) bif ();

    cdc_tx_scheduler #(
        .NUM_REQ(2), .BUS_WIDTH(8), .NUM_STAGES(2), .TIMEOUT_CYCLES(64)
    ) dut (
        .CLK  (clk),
        .RST  (rst),
        .s_if (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        bif.req_valid = '0;
        bif.ack_async = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic wait_grant(output logic [1:0] g, output logic [7:0] b);
        int n;
        n = 0;
        while (bif.req_grant === 2'b00 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL wait_grant: got no grant in %0d cycles expected a grant", n);
        end
        g = bif.req_grant;
        b = bif.unsync_bus;
    endtask

    task automatic complete_txn();
        int n;
        n = 0;
        while (bif.bus_enable !== 1'b1 && n < 50) begin tick(); n++; end
        checks++;
        if (n >= 50) begin failures++; $display("FAIL txn_enable: got enable=%b expected 1", bif.bus_enable); end
        bif.ack_async = 1'b1;
        n = 0;
        while (bif.done !== 1'b1 && n < 50) begin tick(); n++; end
        checks++;
        if (n >= 50) begin failures++; $display("FAIL txn_done: got done=%b expected 1", bif.done); end
        bif.ack_async = 1'b0;
        n = 0;
        while (bif.busy !== 1'b0 && n < 50) begin tick(); n++; end
        checks++;
        if (n >= 50) begin failures++; $display("FAIL txn_idle: got busy=%b expected 0", bif.busy); end
    endtask

    task automatic test_reset();
        bif.req_valid = '0;
        bif.req_data  = '0;
        bif.ack_async = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        checks++; if (bif.req_grant !== 2'b00) begin failures++; $display("FAIL rst_grant: got %b expected 00", bif.req_grant); end
        checks++; if (bif.unsync_bus !== 8'h00) begin failures++; $display("FAIL rst_bus: got %h expected 00", bif.unsync_bus); end
        checks++; if (bif.bus_enable !== 1'b0) begin failures++; $display("FAIL rst_enable: got %b expected 0", bif.bus_enable); end
        checks++; if (bif.done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b expected 0", bif.done); end
        checks++; if (bif.timeout_err !== 1'b0) begin failures++; $display("FAIL rst_timeout: got %b expected 0", bif.timeout_err); end
        checks++; if (bif.busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", bif.busy); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bif.req_valid = 2'b01;
        bif.req_data  = 16'h00A5;
        tick();
        checks++; if (bif.req_grant !== 2'b01) begin failures++; $display("FAIL single_grant: got %b expected 01", bif.req_grant); end
        checks++; if (bif.unsync_bus !== 8'hA5) begin failures++; $display("FAIL single_bus: got %h expected a5", bif.unsync_bus); end
        checks++; if (bif.bus_enable !== 1'b0) begin failures++; $display("FAIL single_setup_en: got %b expected 0", bif.bus_enable); end
        checks++; if (bif.busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b expected 1", bif.busy); end
        bif.req_valid = 2'b00;
        tick();
        checks++; if (bif.bus_enable !== 1'b1) begin failures++; $display("FAIL single_en_rise: got %b expected 1", bif.bus_enable); end
        checks++; if (bif.req_grant !== 2'b00) begin failures++; $display("FAIL single_grant_pulse: got %b expected 00", bif.req_grant); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bif.bus_enable !== 1'b1 || bif.done !== 1'b0) begin
                failures++; $display("FAIL single_send_hold: got en=%b done=%b expected en=1 done=0", bif.bus_enable, bif.done);
            end
        end
        bif.ack_async = 1'b1;
        tick();
        tick();
        checks++; if (bif.bus_enable !== 1'b1 || bif.done !== 1'b0) begin
            failures++; $display("FAIL single_ack_sync: got en=%b done=%b expected en=1 done=0", bif.bus_enable, bif.done);
        end
        tick();
        checks++; if (bif.bus_enable !== 1'b0) begin failures++; $display("FAIL single_en_fall: got %b expected 0", bif.bus_enable); end
        checks++; if (bif.done !== 1'b1) begin failures++; $display("FAIL single_done: got %b expected 1", bif.done); end
        bif.ack_async = 1'b0;
        tick();
        checks++; if (bif.done !== 1'b0 || bif.busy !== 1'b1) begin
            failures++; $display("FAIL single_release: got done=%b busy=%b expected done=0 busy=1", bif.done, bif.busy);
        end
        tick();
        tick();
        checks++; if (bif.busy !== 1'b0) begin failures++; $display("FAIL single_idle: got busy=%b expected 0", bif.busy); end
        checks++; if (bif.unsync_bus !== 8'hA5) begin failures++; $display("FAIL single_bus_hold: got %h expected a5", bif.unsync_bus); end
    endtask

    task automatic test_simultaneous();
        logic [1:0] g;
        logic [7:0] b;
        do_reset();
        bif.req_data  = 16'h2211;
        bif.req_valid = 2'b11;
        wait_grant(g, b);
        checks++; if (g !== 2'b01 || b !== 8'h11) begin failures++; $display("FAIL simul_first: got g=%b bus=%h expected g=01 bus=11", g, b); end
        bif.req_valid = 2'b10;
        complete_txn();
        wait_grant(g, b);
        checks++; if (g !== 2'b10 || b !== 8'h22) begin failures++; $display("FAIL simul_second: got g=%b bus=%h expected g=10 bus=22", g, b); end
        bif.req_valid = 2'b00;
        complete_txn();
    endtask

    task automatic test_fairness();
        logic [1:0] g;
        logic [7:0] b;
        logic [1:0] exp_g;
        logic [7:0] exp_b;
        do_reset();
        bif.req_data  = 16'h4433;
        bif.req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_b = (i % 2 == 0) ? 8'h33 : 8'h44;
            wait_grant(g, b);
            checks++; if (g !== exp_g || b !== exp_b) begin
                failures++; $display("FAIL fair_txn%0d: got g=%b bus=%h expected g=%b bus=%h", i, g, b, exp_g, exp_b);
            end
            complete_txn();
        end
        bif.req_valid = 2'b00;
        tick();
    endtask

    task automatic run_send(input int ack_at, output int n_hi, output logic seen_done);
        int n;
        n = 0;
        while (bif.bus_enable !== 1'b1 && n < 50) begin tick(); n++; end
        checks++;
        if (n >= 50) begin failures++; $display("FAIL send_start: got enable=%b expected 1", bif.bus_enable); end
        n_hi = 0;
        seen_done = 1'b0;
        while (bif.bus_enable === 1'b1 && n_hi < 200) begin
            n_hi++;
            if (bif.done === 1'b1) seen_done = 1'b1;
            if (n_hi == ack_at) bif.ack_async = 1'b1;
            tick();
        end
    endtask

    task automatic test_timeout();
        logic [1:0] g;
        logic [7:0] b;
        int         n_hi;
        logic       seen_done;
        bif.req_data  = 16'h005A;
        bif.req_valid = 2'b01;
        wait_grant(g, b);
        bif.req_valid = 2'b00;
        run_send(-1, n_hi, seen_done);
        checks++; if (n_hi !== 64) begin failures++; $display("FAIL to_enable_len: got %0d expected 64", n_hi); end
        checks++; if (bif.timeout_err !== 1'b1) begin failures++; $display("FAIL to_pulse: got %b expected 1", bif.timeout_err); end
        checks++; if (bif.done !== 1'b0 || seen_done !== 1'b0) begin
            failures++; $display("FAIL to_done: got done=%b seen=%b expected 0", bif.done, seen_done);
        end
        checks++; if (bif.busy !== 1'b1) begin failures++; $display("FAIL to_release_busy: got %b expected 1", bif.busy); end
        tick();
        checks++; if (bif.timeout_err !== 1'b0 || bif.busy !== 1'b0) begin
            failures++; $display("FAIL to_idle: got to=%b busy=%b expected to=0 busy=0", bif.timeout_err, bif.busy);
        end
    endtask

    task automatic test_collision();
        logic [1:0] g;
        logic [7:0] b;
        int         n_hi;
        logic       seen_done;
        int         n;
        bif.req_data  = 16'h00C3;
        bif.req_valid = 2'b01;
        wait_grant(g, b);
        bif.req_valid = 2'b00;
        run_send(62, n_hi, seen_done);
        checks++; if (n_hi !== 64) begin failures++; $display("FAIL coll_enable_len: got %0d expected 64", n_hi); end
        checks++; if (bif.done !== 1'b1) begin failures++; $display("FAIL coll_done: got %b expected 1", bif.done); end
        checks++; if (bif.timeout_err !== 1'b0) begin failures++; $display("FAIL coll_timeout: got %b expected 0", bif.timeout_err); end
        bif.ack_async = 1'b0;
        n = 0;
        while (bif.busy !== 1'b0 && n < 50) begin tick(); n++; end
        checks++; if (n >= 50) begin failures++; $display("FAIL coll_idle: got busy=%b expected 0", bif.busy); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] g;
        logic [7:0] b;
        int         n;
        do_reset();
        bif.req_data  = 16'h0077;
        bif.req_valid = 2'b01;
        wait_grant(g, b);
        bif.req_valid = 2'b00;
        n = 0;
        while (bif.bus_enable !== 1'b1 && n < 50) begin tick(); n++; end
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        checks++; if (bif.bus_enable !== 1'b0) begin failures++; $display("FAIL mid_enable: got %b expected 0", bif.bus_enable); end
        checks++; if (bif.busy !== 1'b0) begin failures++; $display("FAIL mid_busy: got %b expected 0", bif.busy); end
        checks++; if (bif.unsync_bus !== 8'h00) begin failures++; $display("FAIL mid_bus: got %h expected 00", bif.unsync_bus); end
        tick();
        rst = 1'b1;
        bif.req_data  = 16'hBBAA;
        bif.req_valid = 2'b11;
        wait_grant(g, b);
        checks++; if (g !== 2'b01 || b !== 8'hAA) begin failures++; $display("FAIL mid_regrant: got g=%b bus=%h expected g=01 bus=aa", g, b); end
        bif.req_valid = 2'b10;
        complete_txn();
        wait_grant(g, b);
        checks++; if (g !== 2'b10 || b !== 8'hBB) begin failures++; $display("FAIL mid_next: got g=%b bus=%h expected g=10 bus=bb", g, b); end
        bif.req_valid = 2'b00;
        complete_txn();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_timeout();
        test_collision();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cdc_tx_scheduler.md
# cdc_tx_scheduler

Source-domain scheduler that shares one multi-bit CDC channel (data-sync bus plus enable) between NUM_REQ requesters. Captures a winning requester's word, holds it stable on the unsynchronized bus, and drives the enable level under a 4-phase handshake closed by an acknowledge returned from the destination domain. Sits in the source clock domain, directly upstream of the destination-side bus synchronizer.

## Interface
- NUM_REQ, 2: number of requesters (≥2).
- BUS_WIDTH, 8: data word width.
- NUM_STAGES, 2: flops in the internal ack synchronizer (≥2).
- TIMEOUT_CYCLES, 64: maximum SEND cycles without acknowledge.
- CLK  in  1  source-domain clock.
- RST  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  level request per requester; held high until granted.
- req_data  in  NUM_REQ*BUS_WIDTH  requester i occupies bits [i*BUS_WIDTH +: BUS_WIDTH].
- ack_async  in  1  raw acknowledge level from the destination domain.
- req_grant  out  NUM_REQ  one-hot, one-cycle pulse: word captured.
- unsync_bus  out  BUS_WIDTH  word to the synchronizer.
- bus_enable  out  1  enable level to the synchronizer.
- done  out  1  one-cycle pulse: ack received for the current word.
- timeout_err  out  1  one-cycle pulse: SEND timed out.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- ack_async passes through an NUM_STAGES-flop synchronizer to produce ack_s. No other logic samples ack_async.
- States and transitions:
  - IDLE: if any req_valid is high, go to SETUP.
  - SETUP: go to SEND.
  - SEND: if ack_s=1, go to RELEASE. If the timeout counter reaches TIMEOUT_CYCLES-1, go to RELEASE.
  - RELEASE: if ack_s=0, go to IDLE.
- IDLE→SETUP edge:
  - unsync_bus ← winner's data; req_grant[winner] ← 1 for one cycle.
  - Round-robin pointer ← winner+1, mod NUM_REQ.
- Arbitration: search starts at the pointer and ascends cyclically; the first valid requester wins. Reset pointer is 0.
- unsync_bus changes only on the IDLE→SETUP edge. It is held through SETUP, SEND, RELEASE and the following IDLE, and is never cleared except by reset. This gives the destination one full cycle of stable data before enable rises.
- bus_enable:
  - Rises on the SETUP→SEND edge.
  - Falls on the SEND→RELEASE edge.
  - Is 0 in all other states.
- done pulses on the SEND→RELEASE edge only when ack_s=1.
- timeout_err pulses on the SEND→RELEASE edge only on timeout. If ack_s=1 and the timeout hit in the same cycle, the ack wins: done=1, timeout_err=0.
- Timeout counter:
  - Clears on entry to SEND and increments each SEND cycle.
  - Width is $clog2(TIMEOUT_CYCLES); it never wraps.
- In RELEASE after a timeout, ack_s is normally already 0, so RELEASE exits after one cycle. If a late ack arrives, the scheduler waits for it to drop.
- req_valid dropping before grant is a requester protocol violation; the scheduler simply re-arbitrates on current inputs.
- Reset (asynchronous, any state) sets:
  - state=IDLE; pointer=0; counter=0.
  - ack synchronizer = all 0.
  - unsync_bus=0, bus_enable=0, req_grant=0, done=0, timeout_err=0, busy=0.

## Timing
- Request sampled in IDLE at edge t:
  - req_grant and unsync_bus update at t+1.
  - bus_enable=1 from t+2.
- ack_async rising: ack_s is high NUM_STAGES edges later. bus_enable falls and done pulses one edge after that.
- Minimum transaction: IDLE→SETUP→SEND→RELEASE→IDLE. Next grant is ≥1 cycle after RELEASE exit, so back-to-back grants are ≥4 cycles apart plus ack latency.
- Timeout: bus_enable is high for exactly TIMEOUT_CYCLES cycles when no ack arrives.
- All outputs are registered.

## Test plan
- Single request: req_valid=01, req_data[7:0]=0xA5; ack_async raised 5 cycles after bus_enable.
  - Response: req_grant=01 at t+1; unsync_bus=0xA5; bus_enable high from t+2 until NUM_STAGES+1 edges after the ack.
  - done pulse, return to IDLE after the ack drops, unsync_bus still 0xA5.
- Simultaneous request: req_valid=11 from reset, data0=0x11, data1=0x22, each held until its own grant.
  - Response: grant order 0 then 1; unsync_bus sequence 0x11, 0x22.
- Fairness: both valid held continuously for 4 transactions.
  - Response: grants alternate 01,10,01,10.
- Timeout: request with ack_async tied 0, TIMEOUT_CYCLES=64.
  - Response: bus_enable high exactly 64 cycles, timeout_err pulse, done stays 0, IDLE two cycles later.
- Reset mid-transaction: RST low during SEND.
  - Response: bus_enable, busy and unsync_bus drop to 0 asynchronously.
  - After release, a new request is granted to requester 0 first.
- Ack/timeout collision: ack_s rises in the final timeout cycle.
  - Response: done=1, timeout_err=0.
